imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The parameter DEPTH, default 32, SHALL set the instruction-memory capacity in 32-bit words.
REQ-002 The parameter SYNC, default 8'hA5, SHALL set the frame start byte.
REQ-003 The port clk SHALL be an input, 1 bit wide, and is the single clock; all logic is on its rising edge.
REQ-004 The port reset SHALL be an input, 1 bit wide, and is a synchronous, active-low reset.
REQ-005 The port rx_valid SHALL be an input, 1 bit wide, and marks the byte on rx_data as valid.
REQ-006 The port rx_data SHALL be an input, 8 bits wide, and carries the incoming byte.
REQ-007 The port rx_ready SHALL be an output, 1 bit wide; a byte is accepted when rx_valid and rx_ready are both high on a clk edge.
REQ-008 The port imem_we SHALL be an output, 1 bit wide, and is the instruction-memory write strobe (one-cycle pulse).
REQ-009 The port imem_waddr SHALL be an output, 32 bits wide, and carries the byte address of the write.
REQ-010 The port imem_wdata SHALL be an output, 32 bits wide, and carries the instruction word.
REQ-011 The port cpu_reset SHALL be an output, 1 bit wide, and is the active-high reset driven to the CPU core.
REQ-012 The port load_done SHALL be an output, 1 bit wide, and goes high once a program has loaded successfully.
REQ-013 The port load_err SHALL be an output, 1 bit wide, and goes high when a frame is rejected.

Function
REQ-014 A frame SHALL consist of: SYNC, count low byte, count high byte, count*4 payload bytes (each word little-endian), and an optional checksum byte (REQ-030).
REQ-015 The states SHALL be IDLE, CNT_LO, CNT_HI, DATA, CKSUM, DONE and ERR.
REQ-016 In IDLE, an accepted byte equal to SYNC SHALL move the state to CNT_LO; any other byte SHALL be discarded and the state stays IDLE.
REQ-017 CNT_LO SHALL latch the count low byte and then move to CNT_HI.
REQ-018 CNT_HI SHALL latch the count high byte, then go to ERR if count > DEPTH, to CKSUM or DONE if count == 0 (per REQ-030/031), and to DATA otherwise.
REQ-019 In DATA, bytes SHALL be assembled little-endian, so that byte 0 maps to bits [7:0] and byte 3 to bits [31:24].
REQ-020 imem_we SHALL pulse high for exactly one cycle, on the cycle after the 4th byte of a word is accepted, with imem_wdata holding the assembled word.
REQ-021 imem_waddr SHALL be 0 for the first word and increase by 4 per word; it does not wrap, because count is limited to DEPTH.
REQ-022 After the last word's imem_we pulse, the state SHALL go to CKSUM or DONE.
REQ-023 rx_ready SHALL be 1 in IDLE, CNT_LO, CNT_HI, DATA, CKSUM and ERR, and 0 in DONE and during the imem_we cycle, giving a one-cycle backpressure per word.
REQ-024 Gaps in rx_valid SHALL be tolerated in any state with no timeout; partial word and count state are held.
REQ-025 cpu_reset SHALL be 1 in every state except DONE.
REQ-026 DONE SHALL be sticky until reset: load_done=1, cpu_reset=0, and rx_ready=0.
REQ-027 ERR SHALL set load_err=1 and hold cpu_reset=1; an accepted SYNC byte SHALL clear load_err, restart addressing at 0 and enter CNT_LO, while other bytes are discarded.
REQ-028 The byte counter, word counter and checksum SHALL all clear when CNT_LO is entered.

Reset
REQ-029 When reset=0 on a clk edge, the block SHALL enter IDLE with cpu_reset=1, rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, load_done=0, load_err=0 and all counters at 0; rx_ready becomes 1 on the first cycle after reset=1, and a reset mid-frame abandons the frame with no further imem_we.

Configuration
REQ-030 With IMEM_LOADER_CKSUM_EN defined, CKSUM SHALL be entered after the last word, or directly from CNT_HI when count == 0.
REQ-031 With IMEM_LOADER_CKSUM_EN defined, the byte accepted in CKSUM SHALL be compared with the XOR of all payload bytes: equal -> DONE, mismatch -> ERR.
REQ-032 With IMEM_LOADER_CKSUM_EN undefined, CKSUM SHALL be absent, the frame SHALL end after the last payload byte, and the state goes straight to DONE.

Verification
REQ-033 The bench SHALL cover: after reset, send A5 02 00 13 00 00 00 93 0F 10 00 (+ checksum 9F if CKSUM_EN) -> imem_we pulses twice, at addr 0 with 00000013 and at addr 4 with 00100F93; then load_done=1 and cpu_reset=0.
REQ-034 The bench SHALL cover: send A5 21 00 with DEPTH=32 -> load_err=1, no imem_we, cpu_reset=1.
REQ-035 The bench SHALL cover: with CKSUM_EN, send A5 01 00 01 02 03 04 05 (expected 04) -> load_err=1; then send A5 00 00 00 -> load_done=1.
REQ-036 The bench SHALL cover: send FF 00 A5 00 00 (+00 if CKSUM_EN) -> the leading bytes are ignored and load_done=1 with zero writes.
REQ-037 The bench SHALL cover: drop reset to 0 after 2 payload bytes -> all outputs return to the REQ-029 values; a following full frame then writes starting at addr 0.
REQ-038 The bench SHALL cover: hold rx_valid high continuously during DATA -> rx_ready=0 on each imem_we cycle, and no byte is lost or duplicated.

Source files
------------

// File: rtl/imem_loader.sv
// Serial boot loader: receives a framed program over a byte stream and writes it into instruction memory.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader #(
    parameter int         DEPTH = 32,
    parameter logic [7:0] SYNC  = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_err
);

`ifdef IMEM_LOADER_CKSUM_EN
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CKSUM, DONE, ERR} state_t;
    localparam state_t END_ST = CKSUM;
`else
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, DONE, ERR} state_t;
    localparam state_t END_ST = DONE;
`endif

    localparam logic [15:0] DEPTH_CNT = 16'(DEPTH);

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] count_reg;
    logic [15:0] word_cnt_reg;
    logic [1:0]  byte_cnt_reg;
    logic [31:0] word_reg;
    logic        we_reg;
    logic        ready_ok_reg;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]  cksum_reg;
`endif
    logic        accept;
    logic        start;
    logic        last_word;
    logic [15:0] count_full;

    // ready_ok_reg keeps rx_ready low until the first cycle after reset is released
    assign rx_ready   = ready_ok_reg && !we_reg && (state_reg != DONE);
    assign accept     = rx_valid && rx_ready;
    assign count_full = {rx_data, count_reg[7:0]};
    assign last_word  = ((word_cnt_reg + 16'd1) == count_reg);

    assign imem_we    = we_reg;
    assign imem_waddr = {14'd0, word_cnt_reg, 2'b00};
    assign imem_wdata = word_reg;
    assign cpu_reset  = (state_reg != DONE);
    assign load_done  = (state_reg == DONE);
    assign load_err   = (state_reg == ERR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        case (state_reg)
            IDLE, ERR: begin
                if (accept && rx_data == SYNC) begin
                    state_next = CNT_LO;
                    start      = 1'b1;
                end
            end
            CNT_LO: begin
                if (accept) state_next = CNT_HI;
            end
            CNT_HI: begin
                if (accept) begin
                    if (count_full > DEPTH_CNT)   state_next = ERR;
                    else if (count_full == 16'd0) state_next = END_ST;
                    else                          state_next = DATA;
                end
            end
            DATA: begin
                // leave only after the final word's write strobe has been issued
                if (we_reg && last_word) state_next = END_ST;
            end
`ifdef IMEM_LOADER_CKSUM_EN
            CKSUM: begin
                if (accept) state_next = (rx_data == cksum_reg) ? DONE : ERR;
            end
`endif
            DONE: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg    <= 16'd0;
            word_cnt_reg <= 16'd0;
            byte_cnt_reg <= 2'd0;
            we_reg       <= 1'b0;
            ready_ok_reg <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_reg    <= 8'd0;
`endif
        end else begin
            ready_ok_reg <= 1'b1;
            we_reg       <= 1'b0;
            if (start) begin
                word_cnt_reg <= 16'd0;
                byte_cnt_reg <= 2'd0;
`ifdef IMEM_LOADER_CKSUM_EN
                cksum_reg    <= 8'd0;
`endif
            end
            if (state_reg == CNT_LO && accept) count_reg[7:0]  <= rx_data;
            if (state_reg == CNT_HI && accept) count_reg[15:8] <= rx_data;
            if (state_reg == DATA && accept) begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                cksum_reg    <= cksum_reg ^ rx_data;
`endif
                if (byte_cnt_reg == 2'd3) we_reg <= 1'b1;
            end
            if (state_reg == DATA && we_reg) word_cnt_reg <= word_cnt_reg + 16'd1;
        end
    end

    // little-endian assembly: byte n of the word lands in lane n
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    lane_reg <= 8'd0;
                end else if (state_reg == DATA && accept && byte_cnt_reg == 2'(gi)) begin
                    lane_reg <= rx_data;
                end
            end
            assign word_reg[gi*8 +: 8] = lane_reg;
        end
    endgenerate

endmodule
